// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: maps {key_id, key_is_pressed, octave_up, octave_down} to a 50% duty tone.
// Optional `TONE_ATTACK_GAP_EN inserts a silent gap between different notes.
module buzzer_tone_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int KEY_ID_BITS = 3,
  parameter int DIV_WIDTH   = 20,
  parameter int GAP_MS      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_ID_BITS-1:0] key_id,
  input  logic                   key_is_pressed,
  input  logic                   octave_up,
  input  logic                   octave_down,
  output logic                   buzzer_out,
  output logic                   is_sounding,
  output logic [KEY_ID_BITS-1:0] sounding_key_id
);

  // Half-period in clocks = CLK_FREQ_HZ / (2 * f), with f given in centi-hertz.
  localparam logic [63:0] CLK_X50 = 64'(CLK_FREQ_HZ) * 64'd50;
  localparam logic [DIV_WIDTH-1:0] HALF_1 = DIV_WIDTH'(CLK_X50 / 64'd26163);
  localparam logic [DIV_WIDTH-1:0] HALF_2 = DIV_WIDTH'(CLK_X50 / 64'd29366);
  localparam logic [DIV_WIDTH-1:0] HALF_3 = DIV_WIDTH'(CLK_X50 / 64'd32963);
  localparam logic [DIV_WIDTH-1:0] HALF_4 = DIV_WIDTH'(CLK_X50 / 64'd34923);
  localparam logic [DIV_WIDTH-1:0] HALF_5 = DIV_WIDTH'(CLK_X50 / 64'd39200);
  localparam logic [DIV_WIDTH-1:0] HALF_6 = DIV_WIDTH'(CLK_X50 / 64'd44000);
  localparam logic [DIV_WIDTH-1:0] HALF_7 = DIV_WIDTH'(CLK_X50 / 64'd49388);

`ifdef TONE_ATTACK_GAP_EN
  localparam logic [63:0] GAP_CYCLES = 64'(GAP_MS) * 64'(CLK_FREQ_HZ) / 64'd1000;
  localparam logic [DIV_WIDTH-1:0] GAP_LAST = DIV_WIDTH'(GAP_CYCLES - 64'd1);

  typedef enum logic [1:0] {S_SILENT = 2'd0, S_TONE = 2'd1, S_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_SILENT = 2'd0, S_TONE = 2'd1} state_t;
`endif

  state_t                 state, state_n;
  logic [DIV_WIDTH-1:0]   counter, counter_n;
  logic [DIV_WIDTH-1:0]   active_half, active_half_n;
  logic                   buzzer_n, sounding_n;
  logic [KEY_ID_BITS-1:0] sid_n;

  logic [DIV_WIDTH-1:0]   base_half, target_half;
  logic                   target_valid;
  logic                   at_boundary;

  always_comb begin
    base_half = '0;
    case (key_id)
      KEY_ID_BITS'(1): base_half = HALF_1;
      KEY_ID_BITS'(2): base_half = HALF_2;
      KEY_ID_BITS'(3): base_half = HALF_3;
      KEY_ID_BITS'(4): base_half = HALF_4;
      KEY_ID_BITS'(5): base_half = HALF_5;
      KEY_ID_BITS'(6): base_half = HALF_6;
      KEY_ID_BITS'(7): base_half = HALF_7;
      default:         base_half = '0;
    endcase
    target_half = base_half;
    if (octave_up && !octave_down)
      target_half = base_half >> 1;
    else if (octave_down && !octave_up)
      target_half = base_half << 1;
  end

  assign target_valid = key_is_pressed && (key_id != '0);
  assign at_boundary  = (counter == active_half - DIV_WIDTH'(1));

  always_comb begin
    state_n       = state;
    counter_n     = counter;
    active_half_n = active_half;
    buzzer_n      = buzzer_out;
    sounding_n    = is_sounding;
    sid_n         = sounding_key_id;

    case (state)
      S_SILENT: begin
        if (target_valid) begin
          state_n       = S_TONE;
          buzzer_n      = 1'b1;
          sounding_n    = 1'b1;
          counter_n     = '0;
          active_half_n = target_half;
          sid_n         = key_id;
        end else begin
          buzzer_n      = 1'b0;
          sounding_n    = 1'b0;
          counter_n     = '0;
          active_half_n = '0;
          sid_n         = '0;
        end
      end

      S_TONE: begin
        // Release always wins over a coincident phase boundary.
        if (!target_valid) begin
          state_n    = S_SILENT;
          buzzer_n   = 1'b0;
          sounding_n = 1'b0;
          counter_n  = '0;
          sid_n      = '0;
        end else if (at_boundary) begin
          counter_n = '0;
`ifdef TONE_ATTACK_GAP_EN
          if (key_id != sounding_key_id) begin
            state_n    = S_GAP;
            buzzer_n   = 1'b0;
            sounding_n = 1'b0;
            sid_n      = '0;
          end else begin
            buzzer_n      = ~buzzer_out;
            active_half_n = target_half;
            sid_n         = key_id;
          end
`else
          buzzer_n      = ~buzzer_out;
          active_half_n = target_half;
          sid_n         = key_id;
`endif
        end else begin
          counter_n = counter + DIV_WIDTH'(1);
        end
      end

`ifdef TONE_ATTACK_GAP_EN
      S_GAP: begin
        if (!target_valid) begin
          state_n   = S_SILENT;
          counter_n = '0;
        end else if (counter == GAP_LAST) begin
          state_n       = S_TONE;
          buzzer_n      = 1'b1;
          sounding_n    = 1'b1;
          counter_n     = '0;
          active_half_n = target_half;
          sid_n         = key_id;
        end else begin
          counter_n = counter + DIV_WIDTH'(1);
        end
      end
`endif

      default: begin
        state_n       = S_SILENT;
        buzzer_n      = 1'b0;
        sounding_n    = 1'b0;
        counter_n     = '0;
        active_half_n = '0;
        sid_n         = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_SILENT;
      counter         <= '0;
      active_half     <= '0;
      buzzer_out      <= 1'b0;
      is_sounding     <= 1'b0;
      sounding_key_id <= '0;
    end else begin
      state           <= state_n;
      counter         <= counter_n;
      active_half     <= active_half_n;
      buzzer_out      <= buzzer_n;
      is_sounding     <= sounding_n;
      sounding_key_id <= sid_n;
    end
  end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Bench for buzzer_tone_gen: directed level-length checks plus random key traffic against a deadline-based reference.
// Clock frequency is scaled down so whole periods fit in a short run.
module tb_buzzer_tone_gen;

  localparam int CLK_HZ = 200_000;
  localparam int KB     = 3;
  localparam int DW     = 20;
  localparam int GMS    = 1;
  localparam longint GAP_CYC = longint'(GMS) * CLK_HZ / 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KB-1:0] key_id = '0;
  logic          key_is_pressed = 1'b0;
  logic          octave_up = 1'b0;
  logic          octave_down = 1'b0;
  logic          buzzer_out;
  logic          is_sounding;
  logic [KB-1:0] sounding_key_id;

  buzzer_tone_gen #(
    .CLK_FREQ_HZ(CLK_HZ), .KEY_ID_BITS(KB), .DIV_WIDTH(DW), .GAP_MS(GMS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_id(key_id), .key_is_pressed(key_is_pressed),
    .octave_up(octave_up), .octave_down(octave_down), .buzzer_out(buzzer_out),
    .is_sounding(is_sounding), .sounding_key_id(sounding_key_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Note frequencies in centi-hertz; the half-period follows directly from them.
  function automatic int half_for(input int id, input bit up, input bit dn);
    int     f [8] = '{0, 26163, 29366, 32963, 34923, 39200, 44000, 49388};
    longint h;
    if (id == 0) return 0;
    h = (longint'(CLK_HZ) * 50) / f[id];
    if (up && !dn)      h = h / 2;
    else if (dn && !up) h = h * 2;
    return int'(h);
  endfunction

  // Reference: tone is described by its level and the absolute cycle at which that level ends.
  longint cyc = 0;
  bit     m_on = 0, m_lvl = 0, m_gap = 0;
  int     m_sid = 0;
  longint m_deadline = 0, m_gap_end = 0;

  task automatic model_off();
    m_on = 0; m_gap = 0; m_lvl = 0; m_sid = 0;
  endtask

  task automatic model_edge();
    bit valid;
    int th;
    cyc++;
    valid = key_is_pressed && (key_id != 0);
    th    = half_for(int'(key_id), octave_up, octave_down);
    if (!valid) model_off();
    else if ((m_gap && cyc == m_gap_end) || (!m_on && !m_gap)) begin
      m_on = 1; m_gap = 0; m_lvl = 1; m_sid = int'(key_id); m_deadline = cyc + th;
    end else if (m_on && cyc == m_deadline) begin
`ifdef TONE_ATTACK_GAP_EN
      if (int'(key_id) != m_sid) begin
        m_on = 0; m_gap = 1; m_lvl = 0; m_sid = 0; m_gap_end = cyc + GAP_CYC;
      end else
`endif
      begin
        m_lvl = !m_lvl; m_sid = int'(key_id); m_deadline = cyc + th;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("buzz", 32'(buzzer_out), 32'(m_lvl));
    chk("snd", 32'(is_sounding), 32'(m_on));
    chk("sid", 32'(sounding_key_id), 32'(m_sid));
  endtask

  task automatic set_in(input int id, input bit p, input bit u, input bit d);
    key_id = KB'(id); key_is_pressed = p; octave_up = u; octave_down = d;
  endtask

  task automatic wait_toggle(output int len);
    bit prev;
    prev = buzzer_out;
    len  = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      len++;
      if (buzzer_out != prev) return;
    end
    chk("toggle_timeout", 32'd1, 32'd0);
    len = -1;
  endtask

  task automatic align_high();
    int l;
    if (!buzzer_out) wait_toggle(l);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, toggles;
    bit prev;

    repeat (3) @(negedge clk);
    chk("rst_buzz", 32'(buzzer_out), 32'd0);
    chk("rst_snd", 32'(is_sounding), 32'd0);
    chk("rst_sid", 32'(sounding_key_id), 32'd0);
    rst_n = 1'b1;
    model_off();
    repeat (5) tick();

    // Plain A4: first high one cycle after press, then 8 equal levels.
    set_in(6, 1, 0, 0);
    tick();
    chk("start_hi", 32'(buzzer_out), 32'd1);
    chk("start_sid", 32'(sounding_key_id), 32'd6);
    for (int i = 0; i < 8; i++) begin
      wait_toggle(len);
      chk("a4_len", 32'(len), 32'(half_for(6, 0, 0)));
    end

    // Octave changes take effect only after the level in progress.
    for (int k = 0; k < 3; k++) begin
      bit u, d;
      int prev_half;
      prev_half = half_for(6, octave_up, octave_down);
      u = (k != 1); d = (k != 0);
      set_in(6, 1, u, d);
      wait_toggle(len);
      chk("oct_old_len", 32'(len), 32'(prev_half));
      for (int j = 0; j < 2; j++) begin
        wait_toggle(len);
        chk("oct_len", 32'(len), 32'(half_for(6, u, d)));
      end
    end

    // Note change mid high level: that level still completes.
    set_in(6, 1, 0, 0);
    align_high();
    wait_toggle(len);
    align_high();
    repeat (80) tick();
    set_in(1, 1, 0, 0);
    wait_toggle(len);
    chk("chg_phase_len", 32'(80 + len), 32'(half_for(6, 0, 0)));
`ifdef TONE_ATTACK_GAP_EN
    chk("gap_snd", 32'(is_sounding), 32'd0);
    wait_toggle(len);
    chk("gap_len", 32'(len), 32'(GAP_CYC));
`endif
    chk("chg_sid", 32'(sounding_key_id), 32'd1);
    wait_toggle(len);
    chk("c4_len", 32'(len), 32'(half_for(1, 0, 0)));

    // Release mid-level: immediate silence, no further toggles.
    align_high();
    repeat (50) tick();
    set_in(1, 0, 0, 0);
    tick();
    chk("rel_buzz", 32'(buzzer_out), 32'd0);
    chk("rel_snd", 32'(is_sounding), 32'd0);
    toggles = 0;
    prev = buzzer_out;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (buzzer_out != prev) toggles++;
      prev = buzzer_out;
    end
    chk("rel_toggles", 32'(toggles), 32'd0);

    // Rest id with pressed asserted stays silent.
    set_in(0, 1, 0, 0);
    repeat (500) tick();
    chk("rest_snd", 32'(is_sounding), 32'd0);

    // Octave-only change on B4 never inserts a gap.
    set_in(7, 1, 0, 0);
    tick();
    repeat (60) tick();
    set_in(7, 1, 1, 0);
    wait_toggle(len);
    chk("b4_len", 32'(60 + len), 32'(half_for(7, 0, 0)));
    chk("oct_only_snd", 32'(is_sounding), 32'd1);
    wait_toggle(len);
    chk("b4_up_len", 32'(len), 32'(half_for(7, 1, 0)));

    // Asynchronous reset mid-tone, then restart with the key still held.
    set_in(6, 1, 0, 0);
    repeat (300) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_buzz", 32'(buzzer_out), 32'd0);
    chk("arst_snd", 32'(is_sounding), 32'd0);
    chk("arst_sid", 32'(sounding_key_id), 32'd0);
    model_off();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("arst_restart", 32'(buzzer_out), 32'd1);

    // Random key traffic against the reference, every cycle.
    for (int s = 0; s < 150; s++) begin
      set_in(int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(1, 400)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
